// File: rtl/hw_ctrl_pkg.sv
// Shared types and encodings for the hardwired control unit.
package hw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } beat_t;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_RUN  = 3'b000;
  localparam mode_t MODE_RSTO = 3'b001;
  localparam mode_t MODE_WSTO = 3'b010;
  localparam mode_t MODE_RREG = 3'b011;
  localparam mode_t MODE_WREG = 3'b100;

  localparam int unsigned OPC_INT_W = 4;

  localparam logic [OPC_INT_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_INT_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_INT_W-1:0] OP_AND = 4'b0011;
  localparam logic [OPC_INT_W-1:0] OP_INC = 4'b0100;
  localparam logic [OPC_INT_W-1:0] OP_LD  = 4'b0101;
  localparam logic [OPC_INT_W-1:0] OP_ST  = 4'b0110;
  localparam logic [OPC_INT_W-1:0] OP_JC  = 4'b0111;
  localparam logic [OPC_INT_W-1:0] OP_JZ  = 4'b1000;
  localparam logic [OPC_INT_W-1:0] OP_JMP = 4'b1001;
  localparam logic [OPC_INT_W-1:0] OP_XOR = 4'b1010;
  localparam logic [OPC_INT_W-1:0] OP_DEC = 4'b1011;
  localparam logic [OPC_INT_W-1:0] OP_STP = 4'b1110;
  localparam logic [OPC_INT_W-1:0] OP_NOP = 4'b1111;

  typedef struct packed {
    logic       drw;
    logic       pcinc;
    logic       lpc;
    logic       lar;
    logic       pcadd;
    logic       arinc;
    logic       selctl;
    logic       memw;
    logic       stop;
    logic       lir;
    logic       ldz;
    logic       ldc;
    logic       cin;
    logic       m;
    logic       abus;
    logic       sbus;
    logic       mbus;
    logic       short;
    logic       long;
    logic [3:0] s;
  } ctrl_t;

endpackage

// File: rtl/hw_ctrl_seq_decode.sv
// Combinational strobe decode from beat, console mode, phase, register index and opcode.
module hw_ctrl_decode
  import hw_ctrl_pkg::*;
#(
  parameter int unsigned REG_SEL_W = 2,
  parameter int unsigned OPC_W     = 4
) (
  input  beat_t                beat,
  input  mode_t                mode,
  input  logic                 st0,
  input  logic [REG_SEL_W-1:0] idx,
  input  logic [OPC_W-1:0]     ir,
  input  logic                 c,
  input  logic                 z,
  output ctrl_t                ctrl,
  output logic [REG_SEL_W-1:0] rd_sel,
  output logic [REG_SEL_W-1:0] rs_sel
);

  logic [OPC_INT_W-1:0] opc;

  // Codes beyond STP (possible with a wider field) fall through to NOP.
  always_comb begin
    opc = OPC_INT_W'(ir);
    if (32'(ir) > 32'd14) opc = OP_NOP;
  end

  always_comb begin
    ctrl   = '0;
    rd_sel = '0;
    rs_sel = '0;
    if (beat != IDLE) begin
      case (mode)
        MODE_WREG: if (beat == W1) begin
          ctrl.short  = 1'b1;
          ctrl.selctl = 1'b1;
          ctrl.sbus   = 1'b1;
          ctrl.drw    = 1'b1;
          ctrl.stop   = 1'b1;
          rd_sel      = idx;
        end
        MODE_RREG: if (beat == W1) begin
          ctrl.short  = 1'b1;
          ctrl.selctl = 1'b1;
          ctrl.stop   = 1'b1;
          rs_sel      = idx;
          rd_sel      = idx + REG_SEL_W'(1);
        end
        MODE_WSTO: if (beat == W1) begin
          ctrl.short  = 1'b1;
          ctrl.selctl = 1'b1;
          ctrl.stop   = 1'b1;
          ctrl.sbus   = 1'b1;
          ctrl.lar    = ~st0;
          ctrl.memw   = st0;
          ctrl.arinc  = st0;
        end
        MODE_RSTO: if (beat == W1) begin
          ctrl.short  = 1'b1;
          ctrl.selctl = 1'b1;
          ctrl.stop   = 1'b1;
          ctrl.lar    = ~st0;
          ctrl.sbus   = ~st0;
          ctrl.mbus   = st0;
          ctrl.arinc  = st0;
        end
        MODE_RUN: begin
          if (!st0) begin
            if (beat == W1) begin
              ctrl.lpc   = 1'b1;
              ctrl.sbus  = 1'b1;
              ctrl.short = 1'b1;
              ctrl.stop  = 1'b1;
            end
          end else if (beat == W1) begin
            ctrl.lir   = 1'b1;
            ctrl.pcinc = 1'b1;
          end else if (beat == W2) begin
            case (opc)
              OP_ADD: begin ctrl.s = 4'b1001; ctrl.cin = 1'b1;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1; end
              OP_SUB: begin ctrl.s = 4'b0110;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1; end
              OP_AND: begin ctrl.s = 4'b1011; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; end
              OP_INC: begin ctrl.s = 4'b0000;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1; end
              OP_LD:  begin ctrl.s = 4'b1010; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.lar = 1'b1; ctrl.long = 1'b1; end
              OP_ST:  begin ctrl.s = 4'b1111; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.lar = 1'b1; ctrl.long = 1'b1; end
              OP_JC:  ctrl.pcadd = c;
              OP_JZ:  ctrl.pcadd = z;
              OP_JMP: begin ctrl.s = 4'b1111; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.lpc = 1'b1; end
              OP_XOR: begin ctrl.s = 4'b0110; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; end
              OP_DEC: begin ctrl.s = 4'b1111; ctrl.cin = 1'b1;
                ctrl.abus = 1'b1; ctrl.drw = 1'b1; ctrl.ldz = 1'b1; ctrl.ldc = 1'b1; end
              OP_STP: ctrl.stop = 1'b1;
              default: ;
            endcase
          end else begin
            // Second execute beat, reached only by the long-cycle memory ops.
            case (opc)
              OP_LD: begin ctrl.mbus = 1'b1; ctrl.drw = 1'b1; end
              OP_ST: begin ctrl.s = 4'b1010; ctrl.m = 1'b1;
                ctrl.abus = 1'b1; ctrl.memw = 1'b1; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hw_ctrl_seq.sv
// Hardwired control unit: beat generator, console phase/mode/index state and strobe outputs.
module hw_ctrl_seq #(
  parameter int unsigned REG_SEL_W = 2,
  parameter int unsigned OPC_W     = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [2:0]           sw,
  input  logic                 step_mode,
  input  logic [OPC_W-1:0]     ir,
  input  logic                 c,
  input  logic                 z,
  output logic                 w1,
  output logic                 w2,
  output logic                 w3,
  output logic                 st0,
  output logic                 drw,
  output logic                 pcinc,
  output logic                 lpc,
  output logic                 lar,
  output logic                 pcadd,
  output logic                 arinc,
  output logic                 selctl,
  output logic                 memw,
  output logic                 stop,
  output logic                 lir,
  output logic                 ldz,
  output logic                 ldc,
  output logic                 cin,
  output logic                 m,
  output logic                 abus,
  output logic                 sbus,
  output logic                 mbus,
  output logic                 short,
  output logic                 long,
  output logic [3:0]           s,
  output logic [REG_SEL_W-1:0] rd_sel,
  output logic [REG_SEL_W-1:0] rs_sel
);
  import hw_ctrl_pkg::*;

  beat_t                beat, beat_nxt;
  mode_t                mode, mode_nxt;
  logic                 st0_q, st0_nxt;
  logic [REG_SEL_W-1:0] idx, idx_nxt;
  ctrl_t                ctrl_dec, ctrl_fin;
  logic [REG_SEL_W-1:0] rd_dec, rs_dec;

  hw_ctrl_decode #(
    .REG_SEL_W (REG_SEL_W),
    .OPC_W     (OPC_W)
  ) u_decode (
    .beat   (beat),
    .mode   (mode),
    .st0    (st0_q),
    .idx    (idx),
    .ir     (ir),
    .c      (c),
    .z      (z),
    .ctrl   (ctrl_dec),
    .rd_sel (rd_dec),
    .rs_sel (rs_dec)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      beat  <= IDLE;
      mode  <= MODE_RUN;
      st0_q <= 1'b0;
      idx   <= '0;
    end else begin
      beat  <= beat_nxt;
      mode  <= mode_nxt;
      st0_q <= st0_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    beat_nxt = beat;
    mode_nxt = mode;
    st0_nxt  = st0_q;
    idx_nxt  = idx;
    unique case (beat)
      IDLE: if (start) begin
        beat_nxt = W1;
        if (sw != mode) begin
          mode_nxt = sw;
          st0_nxt  = 1'b0;
          idx_nxt  = '0;
        end
      end
      W1: beat_nxt = ctrl_fin.short ? W1 : W2;
      W2: beat_nxt = ctrl_fin.long ? W3 : W1;
      W3: beat_nxt = W1;
    endcase
    if (beat != IDLE && ctrl_fin.stop) beat_nxt = IDLE;
    // Console index walks and the one-shot phase flag advance at the end of W1.
    if (beat == W1) begin
      case (mode)
        MODE_WREG: idx_nxt = idx + REG_SEL_W'(1);
        MODE_RREG: idx_nxt = idx + REG_SEL_W'(2);
        MODE_WSTO, MODE_RSTO, MODE_RUN: if (!st0_q) st0_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_fin = ctrl_dec;
    // Single-step halts in whichever beat ends the current instruction.
    if (step_mode && mode == MODE_RUN && st0_q &&
        ((beat == W2 && !ctrl_dec.long) || beat == W3))
      ctrl_fin.stop = 1'b1;
    w1     = (beat == W1);
    w2     = (beat == W2);
    w3     = (beat == W3);
    st0    = st0_q;
    drw    = ctrl_fin.drw;
    pcinc  = ctrl_fin.pcinc;
    lpc    = ctrl_fin.lpc;
    lar    = ctrl_fin.lar;
    pcadd  = ctrl_fin.pcadd;
    arinc  = ctrl_fin.arinc;
    selctl = ctrl_fin.selctl;
    memw   = ctrl_fin.memw;
    stop   = ctrl_fin.stop;
    lir    = ctrl_fin.lir;
    ldz    = ctrl_fin.ldz;
    ldc    = ctrl_fin.ldc;
    cin    = ctrl_fin.cin;
    m      = ctrl_fin.m;
    abus   = ctrl_fin.abus;
    sbus   = ctrl_fin.sbus;
    mbus   = ctrl_fin.mbus;
    short  = ctrl_fin.short;
    long   = ctrl_fin.long;
    s      = ctrl_fin.s;
    rd_sel = rd_dec;
    rs_sel = rs_dec;
  end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// Directed bench for hw_ctrl_seq: console walks, run-mode instructions, single-step and reset.
module tb_hw_ctrl_seq;

  localparam int unsigned REG_SEL_W = 2;
  localparam int unsigned OPC_W     = 4;

  logic clk, clr, start, step_mode, c, z;
  logic [2:0] sw;
  logic [OPC_W-1:0] ir;
  logic w1, w2, w3, st0;
  logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir, ldz, ldc;
  logic cin, m, abus, sbus, mbus, short, long;
  logic [3:0] s;
  logic [REG_SEL_W-1:0] rd_sel, rs_sel;

  int n_tests = 0;
  int n_fail  = 0;

  hw_ctrl_seq #(.REG_SEL_W(REG_SEL_W), .OPC_W(OPC_W)) dut (
    .clk(clk), .clr(clr), .start(start), .sw(sw), .step_mode(step_mode),
    .ir(ir), .c(c), .z(z),
    .w1(w1), .w2(w2), .w3(w3), .st0(st0),
    .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar), .pcadd(pcadd), .arinc(arinc),
    .selctl(selctl), .memw(memw), .stop(stop), .lir(lir), .ldz(ldz), .ldc(ldc),
    .cin(cin), .m(m), .abus(abus), .sbus(sbus), .mbus(mbus), .short(short),
    .long(long), .s(s), .rd_sel(rd_sel), .rs_sel(rs_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {beat(3), strobes(19), s(4)} packed for whole-vector checks
  logic [25:0] outs;
  assign outs = {w1, w2, w3,
                 drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir,
                 ldz, ldc, cin, m, abus, sbus, mbus, short, long, s};

  function automatic logic [25:0] vec(input logic [2:0] beat,
                                      input logic [18:0] stb, input logic [3:0] sv);
    return {beat, stb, sv};
  endfunction

  // Strobe bit positions inside the 19-bit strobe field
  localparam logic [18:0] B_DRW = 19'h40000, B_PCINC = 19'h20000, B_LPC = 19'h10000,
    B_LAR = 19'h08000, B_PCADD = 19'h04000, B_ARINC = 19'h02000, B_SELCTL = 19'h01000,
    B_MEMW = 19'h00800, B_STOP = 19'h00400, B_LIR = 19'h00200, B_LDZ = 19'h00100,
    B_LDC = 19'h00080, B_CIN = 19'h00040, B_M = 19'h00020, B_ABUS = 19'h00010,
    B_SBUS = 19'h00008, B_MBUS = 19'h00004, B_SHORT = 19'h00002, B_LONG = 19'h00001;
  localparam logic [2:0] BT_IDLE = 3'b000, BT_W1 = 3'b100, BT_W2 = 3'b010, BT_W3 = 3'b001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_beat();
    @(posedge clk);
    #1;
  endtask

  // Called from IDLE at posedge+1; returns at posedge+1 of the first W1 beat.
  task automatic start_beat();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1;
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_sel", 32'({st0, rd_sel, rs_sel}), 32'd0);
    #1;
    clr = 1'b1;
    next_beat();
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; sw = 3'b000; step_mode = 1'b0; ir = '0; c = 1'b0; z = 1'b0;
    #1;
    do_reset();

    // Register write walk with wrap
    sw = 3'b100;
    for (int k = 0; k < 5; k++) begin
      start_beat();
      check($sformatf("wreg_outs%0d", k), 32'(outs),
            32'(vec(BT_W1, B_SELCTL | B_SBUS | B_DRW | B_STOP | B_SHORT, 4'h0)));
      check($sformatf("wreg_rd%0d", k), 32'(rd_sel), 32'(k % 4));
      next_beat();
      check($sformatf("wreg_idle%0d", k), 32'({w1, w2, w3}), 32'd0);
    end

    // Mode switch clears the index
    do_reset();
    sw = 3'b100;
    start_beat(); next_beat();
    start_beat();
    check("wreg2_rd", 32'(rd_sel), 32'd1);
    next_beat();
    sw = 3'b011;
    start_beat();
    check("rreg0_outs", 32'(outs), 32'(vec(BT_W1, B_SELCTL | B_STOP | B_SHORT, 4'h0)));
    check("rreg0_sel", 32'({rs_sel, rd_sel}), 32'({2'd0, 2'd1}));
    next_beat();
    start_beat();
    check("rreg1_sel", 32'({rs_sel, rd_sel}), 32'({2'd2, 2'd3}));
    next_beat();
    start_beat();
    check("rreg2_sel", 32'({rs_sel, rd_sel}), 32'({2'd0, 2'd1}));
    next_beat();

    // Memory write / read console phases
    sw = 3'b010;
    start_beat();
    check("wsto0", 32'({st0, outs}), 32'({1'b0, vec(BT_W1, B_LAR | B_SBUS | B_SELCTL | B_STOP | B_SHORT, 4'h0)}));
    next_beat();
    start_beat();
    check("wsto1", 32'({st0, outs}), 32'({1'b1, vec(BT_W1, B_SBUS | B_MEMW | B_ARINC | B_SELCTL | B_STOP | B_SHORT, 4'h0)}));
    next_beat();
    sw = 3'b001;
    start_beat();
    check("rsto0", 32'({st0, outs}), 32'({1'b0, vec(BT_W1, B_LAR | B_SBUS | B_SELCTL | B_STOP | B_SHORT, 4'h0)}));
    next_beat();
    start_beat();
    check("rsto1", 32'({st0, outs}), 32'({1'b1, vec(BT_W1, B_MBUS | B_ARINC | B_SELCTL | B_STOP | B_SHORT, 4'h0)}));
    next_beat();

    // Run mode: PC load then ADD, LD, JC, JZ, NOP, STP
    do_reset();
    sw = 3'b000;
    start_beat();
    check("pcload", 32'({st0, outs}), 32'({1'b0, vec(BT_W1, B_LPC | B_SBUS | B_SHORT | B_STOP, 4'h0)}));
    next_beat();
    check("pcload_idle", 32'({st0, w1, w2, w3}), 32'(4'b1000));
    ir = 4'b0001;
    start_beat();
    check("fetch", 32'(outs), 32'(vec(BT_W1, B_LIR | B_PCINC, 4'h0)));
    next_beat();
    check("add_w2", 32'(outs), 32'(vec(BT_W2, B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC, 4'b1001)));
    next_beat();
    check("add_next", 32'({w1, w2, w3}), 32'(BT_W1));
    ir = 4'b0101;
    next_beat();
    check("ld_w2", 32'(outs), 32'(vec(BT_W2, B_M | B_ABUS | B_LAR | B_LONG, 4'b1010)));
    next_beat();
    check("ld_w3", 32'(outs), 32'(vec(BT_W3, B_MBUS | B_DRW, 4'h0)));
    next_beat();
    check("ld_next", 32'({w1, w2, w3}), 32'(BT_W1));
    ir = 4'b0111; c = 1'b0;
    next_beat();
    check("jc_c0", 32'({w2, pcadd}), 32'(2'b10));
    c = 1'b1;
    #1;
    check("jc_c1", 32'({w2, pcadd}), 32'(2'b11));
    next_beat();
    ir = 4'b1000; z = 1'b1; c = 1'b0;
    next_beat();
    check("jz_z1", 32'({w2, pcadd}), 32'(2'b11));
    next_beat();
    ir = 4'b1111;
    next_beat();
    check("nop_w2", 32'(outs), 32'(vec(BT_W2, 19'h0, 4'h0)));
    next_beat();
    ir = 4'b1110;
    next_beat();
    check("stp_w2", 32'(outs), 32'(vec(BT_W2, B_STOP, 4'h0)));
    next_beat();
    check("stp_idle", 32'({st0, w1, w2, w3}), 32'(4'b1000));

    // Single-step: ADD halts in W2, LD halts in W3
    step_mode = 1'b1;
    ir = 4'b0001;
    start_beat();
    check("step_fetch_stop", 32'({w1, stop}), 32'(2'b10));
    next_beat();
    check("step_add_w2", 32'({w2, stop, drw}), 32'(3'b111));
    next_beat();
    check("step_add_idle", 32'({w1, w2, w3}), 32'd0);
    ir = 4'b0101;
    start_beat(); next_beat();
    check("step_ld_w2", 32'({w2, stop, long}), 32'(3'b101));
    next_beat();
    check("step_ld_w3", 32'({w3, stop}), 32'(2'b11));
    next_beat();
    check("step_ld_idle", 32'({w1, w2, w3}), 32'd0);
    step_mode = 1'b0;

    // ST: reset mid-W2, then a full ST with its W3 beat
    ir = 4'b0110;
    start_beat(); next_beat();
    check("st_w2", 32'(outs), 32'(vec(BT_W2, B_M | B_ABUS | B_LAR | B_LONG, 4'b1111)));
    do_reset();
    check("post_rst_idle", 32'({st0, w1, w2, w3}), 32'd0);
    start_beat(); next_beat();
    start_beat(); next_beat();
    check("st_w2b", 32'({w2, long}), 32'(2'b11));
    next_beat();
    check("st_w3", 32'(outs), 32'(vec(BT_W3, B_M | B_ABUS | B_MEMW, 4'b1010)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hw_ctrl_seq.md
Name: hw_ctrl_seq

Overview:
- Hardwired control unit for the teaching CPU, the successor to the combinational-only controller.
- Contains its own beat generator (W1/W2/W3 with short/long cycles), the console-mode phase flag st0, a latched mode, and a register-index counter.
- Console register read/write therefore walks all 2**REG_SEL_W registers instead of a fixed two-phase sequence.
- Drives datapath strobes, ALU function, bus enables and register selects; adds a single-step run mode.

Parameters:
- REG_SEL_W, 2, width of each register select; register count = 2**REG_SEL_W (legal 1..4).
- OPC_W, 4, opcode field width taken from IR[7:8-OPC_W]; opcodes above 4'b1110 decode as NOP.

Ports:
- clk  in  1  beat clock; all state advances on rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start pulse (QD); leaves IDLE
- sw  in  3  console mode {swc,swb,swa}
- step_mode  in  1  1 = halt after each executed instruction
- ir  in  OPC_W  opcode field
- c, z  in  1  ALU carry / zero flags
- w1, w2, w3  out  1  current beat, one-hot or all 0 in IDLE
- st0  out  1  phase flag
- drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir, ldz, ldc, cin, m, abus, sbus, mbus, short, long  out  1  control strobes
- s  out  4  ALU function select
- rd_sel, rs_sel  out  REG_SEL_W  destination / source register select

Behaviour:
- Reset (clr=0, async): beat = IDLE, st0 = 0, idx = 0, mode = 000. All outputs are 0 immediately. A reset in mid-beat aborts that beat with no strobe glitch held.
- Beat FSM states: IDLE, W1, W2, W3.
  - IDLE -> W1 on start. start is ignored in any other state.
  - W1 -> W1 if short, else W2.
  - W2 -> W3 if long, else W1.
  - W3 -> W1.
  - Any beat with stop=1 goes to IDLE on the next edge; stop takes priority over short and long.
- Mode latch: on the IDLE -> W1 transition, if sw differs from the latched mode, then mode <= sw, st0 <= 0, idx <= 0 for that same beat. Decoding uses the sampled sw.
- Outputs are combinational from (beat, mode, st0, idx, ir, c, z) and are valid for the whole beat.
- Mode 100, write registers: W1 only, with short=1.
  - Strobes: selctl, sbus, drw, stop; rd_sel = idx.
  - idx increments after each write and wraps to 0 after the last register.
- Mode 011, read registers: W1 only, with short=1.
  - Strobes: selctl, stop; rs_sel = idx, rd_sel = idx+1 (modulo count).
  - idx increments by 2 and wraps.
- Mode 010, write memory: W1, with short=1.
  - st0=0: lar, sbus, selctl, stop; st0 <= 1.
  - st0=1: sbus, memw, arinc, selctl, stop.
- Mode 001, read memory: W1, with short=1.
  - st0=0: lar, sbus, selctl, stop; st0 <= 1.
  - st0=1: mbus, arinc, selctl, stop.
- Mode 000, run:
  - st0=0: W1 does lpc, sbus, short, stop; st0 <= 1.
  - st0=1, W1: lir and pcinc (fetch).
  - st0=1, W2/W3: execute the opcode.
  - stop is also forced in the final beat of each instruction when step_mode=1.
- Execute encodings, {s, m, cin}:
  - ADD 0001: W2 1001,0,1; abus, drw, ldz, ldc.
  - SUB 0010: W2 0110,0,0; abus, drw, ldz, ldc.
  - AND 0011: W2 1011,1,0; abus, drw, ldz.
  - INC 0100: W2 0000,0,0; abus, drw, ldz, ldc.
  - LD 0101: W2 1010,1; abus, lar, long. W3 mbus, drw.
  - ST 0110: W2 1111,1; abus, lar, long. W3 1010,1; abus, memw.
  - JC 0111: W2 pcadd = c.
  - JZ 1000: W2 pcadd = z.
  - JMP 1001: W2 1111,1; abus, lpc.
  - XOR 1010: W2 0110,1; abus, drw, ldz.
  - DEC 1011: W2 1111,0,1; abus, drw, ldz, ldc.
  - STP 1110: W2 stop.
  - NOP: W2 with no strobes.
- Instruction end: W2 when long=0, otherwise W3.

Decomposition:
- Package hw_ctrl_pkg holds:
  - beat_t enum {IDLE, W1, W2, W3};
  - mode_t constants MODE_RUN=000, MODE_RSTO=001, MODE_WSTO=010, MODE_RREG=011, MODE_WREG=100;
  - opcode localparams;
  - a packed ctrl_t struct of all strobes.
- One sub-module, hw_ctrl_decode: purely combinational (beat, mode, st0, idx, ir, c, z) -> ctrl_t.
- The top level holds the FSM, st0, mode latch and idx.

Test Plan:
- WREG walk: REG_SEL_W=2, sw=100, four start pulses -> rd_sel 0,1,2,3, each beat drw=1 and stop=1; a fifth start gives rd_sel=0 (wrap).
- Mode switch: after 2 WREG writes, change sw to 011 and pulse start -> idx cleared, rs_sel=0 and rd_sel=1; next start gives rs_sel=2, rd_sel=3.
- Run ADD: sw=000, PC load (st0 goes 0->1), then ir=0001 -> W1 lir=pcinc=1; W2 s=1001, cin=1, drw=ldz=ldc=1; next beat is W1.
- LD long cycle: ir=0101 -> W2 lar=1, long=1, s=1010, m=1; W3 mbus=1, drw=1; then W1.
- JC/JZ: ir=0111 with c=0 -> pcadd=0; with c=1 -> pcadd=1. ir=1000 with z=1 -> pcadd=1.
- step_mode=1 with ADD -> stop=1 in W2, state is IDLE after the edge. clr pulsed low during W2 of ST -> all outputs 0 at once, st0=0, state IDLE.
